// File: rtl/decode_stage.sv
// Single-entry decode stage for an RV32I subset: decodes one instruction into
// control fields and an extended immediate, held in a ready/valid output register.
module decode_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            ALUControl,
    output logic                  ALUSrc,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic [1:0]            ResultSrc,
    output logic                  Branch,
    output logic                  Jump,
    output logic [DATA_WIDTH-1:0] ImmExt,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SH,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_sel_t;

    // Immediate formats; all signed forms replicate instr[31] into the upper bits.
    function automatic logic [DATA_WIDTH-1:0] imm_ext(input imm_sel_t sel,
                                                      input logic [DATA_WIDTH-1:0] ins);
        logic signed [DATA_WIDTH-1:0] v;
        case (sel)
            IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
            IMM_SH:  v = {27'b0, ins[24:20]};
            IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   v = {ins[31:12], 12'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [3:0] alu_ctrl_p0;
    logic       alu_src_p0;
    logic       reg_wr_p0;
    logic       mem_wr_p0;
    logic [1:0] res_src_p0;
    logic       branch_p0;
    logic       jump_p0;
    logic       illegal_p0;
    imm_sel_t   imm_sel_p0;
    logic [DATA_WIDTH-1:0] imm_p0;

    // Stage p0: combinational decode of the offered instruction.
    always_comb begin
        alu_ctrl_p0 = 4'b0000;
        alu_src_p0  = 1'b0;
        reg_wr_p0   = 1'b0;
        mem_wr_p0   = 1'b0;
        res_src_p0  = 2'b00;
        branch_p0   = 1'b0;
        jump_p0     = 1'b0;
        illegal_p0  = 1'b0;
        imm_sel_p0  = IMM_NONE;

        case (opcode)
            OP_R: begin
                reg_wr_p0 = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: alu_ctrl_p0 = 4'b0000;
                    {F7_ALT,  3'b000}: alu_ctrl_p0 = 4'b1000;
                    {F7_BASE, 3'b001}: alu_ctrl_p0 = 4'b0111;
                    {F7_BASE, 3'b101}: alu_ctrl_p0 = 4'b1001;
                    {F7_BASE, 3'b100}: alu_ctrl_p0 = 4'b1010;
                    {F7_BASE, 3'b110}: alu_ctrl_p0 = 4'b1011;
                    {F7_BASE, 3'b111}: alu_ctrl_p0 = 4'b1100;
                    default:           illegal_p0  = 1'b1;
                endcase
            end
            OP_I: begin
                reg_wr_p0  = 1'b1;
                alu_src_p0 = 1'b1;
                imm_sel_p0 = IMM_I;
                case (funct3)
                    3'b000: alu_ctrl_p0 = 4'b0000;
                    3'b100: alu_ctrl_p0 = 4'b1010;
                    3'b110: alu_ctrl_p0 = 4'b1011;
                    3'b111: alu_ctrl_p0 = 4'b1100;
                    3'b001: begin
                        alu_ctrl_p0 = 4'b0111;
                        imm_sel_p0  = IMM_SH;
                        illegal_p0  = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        alu_ctrl_p0 = 4'b1001;
                        imm_sel_p0  = IMM_SH;
                        illegal_p0  = (funct7 != F7_BASE);
                    end
                    default: illegal_p0 = 1'b1;
                endcase
            end
            OP_LOAD: begin
                alu_ctrl_p0 = 4'b0101;
                alu_src_p0  = 1'b1;
                reg_wr_p0   = 1'b1;
                res_src_p0  = 2'b01;
                imm_sel_p0  = IMM_I;
                illegal_p0  = (funct3 != 3'b100);
            end
            OP_STORE: begin
                alu_ctrl_p0 = 4'b0110;
                alu_src_p0  = 1'b1;
                mem_wr_p0   = 1'b1;
                imm_sel_p0  = IMM_S;
                illegal_p0  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                branch_p0  = 1'b1;
                imm_sel_p0 = IMM_B;
                case (funct3)
                    3'b000:  alu_ctrl_p0 = 4'b1101;
                    3'b001:  alu_ctrl_p0 = 4'b0001;
                    default: illegal_p0  = 1'b1;
                endcase
            end
            OP_JAL: begin
                alu_ctrl_p0 = 4'b0010;
                alu_src_p0  = 1'b1;
                reg_wr_p0   = 1'b1;
                jump_p0     = 1'b1;
                res_src_p0  = 2'b10;
                imm_sel_p0  = IMM_J;
            end
            OP_JALR: begin
                alu_ctrl_p0 = 4'b0011;
                alu_src_p0  = 1'b1;
                reg_wr_p0   = 1'b1;
                jump_p0     = 1'b1;
                res_src_p0  = 2'b10;
                imm_sel_p0  = IMM_I;
                illegal_p0  = (funct3 != 3'b000);
            end
            OP_LUI: begin
                alu_ctrl_p0 = 4'b0100;
                alu_src_p0  = 1'b1;
                reg_wr_p0   = 1'b1;
                imm_sel_p0  = IMM_U;
            end
            default: illegal_p0 = 1'b1;
        endcase

        // Unsupported encodings must not have side effects downstream.
        if (illegal_p0) begin
            alu_ctrl_p0 = 4'b0000;
            alu_src_p0  = 1'b0;
            reg_wr_p0   = 1'b0;
            mem_wr_p0   = 1'b0;
            res_src_p0  = 2'b00;
            branch_p0   = 1'b0;
            jump_p0     = 1'b0;
            imm_sel_p0  = IMM_NONE;
        end
    end

    assign imm_p0 = imm_ext(imm_sel_p0, instr);

    logic                  vld_p1;
    logic [3:0]            alu_ctrl_p1;
    logic                  alu_src_p1;
    logic                  reg_wr_p1;
    logic                  mem_wr_p1;
    logic [1:0]            res_src_p1;
    logic                  branch_p1;
    logic                  jump_p1;
    logic                  illegal_p1;
    logic [DATA_WIDTH-1:0] imm_p1;
    logic [4:0]            rs1_p1;
    logic [4:0]            rs2_p1;
    logic [4:0]            rd_p1;
    logic [DATA_WIDTH-1:0] pc_p1;
    logic                  xfer;

    assign instr_ready = !vld_p1 || out_ready;
    assign xfer        = instr_valid && instr_ready && !flush;

    // Stage p1: output register; flush wins over both accept and consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (xfer) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ctrl_p1 <= '0;
            alu_src_p1  <= 1'b0;
            reg_wr_p1   <= 1'b0;
            mem_wr_p1   <= 1'b0;
            res_src_p1  <= '0;
            branch_p1   <= 1'b0;
            jump_p1     <= 1'b0;
            illegal_p1  <= 1'b0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            pc_p1       <= '0;
        end else if (xfer) begin
            alu_ctrl_p1 <= alu_ctrl_p0;
            alu_src_p1  <= alu_src_p0;
            reg_wr_p1   <= reg_wr_p0;
            mem_wr_p1   <= mem_wr_p0;
            res_src_p1  <= res_src_p0;
            branch_p1   <= branch_p0;
            jump_p1     <= jump_p0;
            illegal_p1  <= illegal_p0;
            imm_p1      <= imm_p0;
            rs1_p1      <= instr[19:15];
            rs2_p1      <= instr[24:20];
            rd_p1       <= instr[11:7];
            pc_p1       <= pc;
        end
    end

    assign out_valid  = vld_p1;
    assign ALUControl = alu_ctrl_p1;
    assign ALUSrc     = alu_src_p1;
    assign RegWrite   = reg_wr_p1;
    assign MemWrite   = mem_wr_p1;
    assign ResultSrc  = res_src_p1;
    assign Branch     = branch_p1;
    assign Jump       = jump_p1;
    assign ImmExt     = imm_p1;
    assign rs1        = rs1_p1;
    assign rs2        = rs2_p1;
    assign rd         = rd_p1;
    assign pc_out     = pc_p1;
    assign illegal    = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded instructions with expected
// decode fields, plus backpressure, flush and asynchronous reset scenarios.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALUControl;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic        Branch;
    logic        Jump;
    logic [31:0] ImmExt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc_out;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch), .Jump(Jump),
        .ImmExt(ImmExt), .rs1(rs1), .rs2(rs2), .rd(rd),
        .pc_out(pc_out), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Offer one instruction for a single edge, then sample 1 time unit later.
    task automatic send(input logic [31:0] ins, input logic [31:0] addr);
        instr       = ins;
        pc          = addr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_instr_ready", 32'(instr_ready), 32'h1);
        check("rst_alu", 32'(ALUControl), 32'h0);
        check("rst_imm", ImmExt, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(32'hFFF00293, 32'h0000_0100);
        check("addi_valid", 32'(out_valid), 32'h1);
        check("addi_alu", 32'(ALUControl), 32'h0);
        check("addi_src", 32'(ALUSrc), 32'h1);
        check("addi_regw", 32'(RegWrite), 32'h1);
        check("addi_imm", ImmExt, 32'hFFFFFFFF);
        check("addi_rd", 32'(rd), 32'd5);
        check("addi_pc", pc_out, 32'h0000_0100);

        send(32'hFE209EE3, 32'h0000_0104);
        check("bne_valid", 32'(out_valid), 32'h1);
        check("bne_alu", 32'(ALUControl), 32'h1);
        check("bne_branch", 32'(Branch), 32'h1);
        check("bne_regw", 32'(RegWrite), 32'h0);
        check("bne_imm", ImmExt, 32'hFFFFFFFC);
        check("bne_rs1", 32'(rs1), 32'd1);
        check("bne_rs2", 32'(rs2), 32'd2);

        send(32'h123450B7, 32'h0000_0108);
        check("lui_alu", 32'(ALUControl), 32'h4);
        check("lui_imm", ImmExt, 32'h12345000);
        check("lui_ressrc", 32'(ResultSrc), 32'h0);
        check("lui_rd", 32'(rd), 32'd1);

        send(32'h402081B3, 32'h0000_010C);
        check("sub_alu", 32'(ALUControl), 32'h8);
        check("sub_src", 32'(ALUSrc), 32'h0);
        check("sub_imm", ImmExt, 32'h0);

        send(32'h002082A3, 32'h0000_0110);
        check("sb_alu", 32'(ALUControl), 32'h6);
        check("sb_memw", 32'(MemWrite), 32'h1);
        check("sb_regw", 32'(RegWrite), 32'h0);
        check("sb_imm", ImmExt, 32'h5);

        send(32'h0000C203, 32'h0000_0114);
        check("lbu_alu", 32'(ALUControl), 32'h5);
        check("lbu_ressrc", 32'(ResultSrc), 32'h1);
        check("lbu_regw", 32'(RegWrite), 32'h1);

        send(32'h008000EF, 32'h0000_0118);
        check("jal_alu", 32'(ALUControl), 32'h2);
        check("jal_jump", 32'(Jump), 32'h1);
        check("jal_ressrc", 32'(ResultSrc), 32'h2);
        check("jal_imm", ImmExt, 32'h8);

        send(32'h00309093, 32'h0000_011C);
        check("slli_alu", 32'(ALUControl), 32'h7);
        check("slli_imm", ImmExt, 32'h3);

        send(32'h4030D093, 32'h0000_0120);
        check("srai_illegal", 32'(illegal), 32'h1);
        check("srai_regw", 32'(RegWrite), 32'h0);
        check("srai_imm", ImmExt, 32'h0);

        send(32'h00000000, 32'h0000_0124);
        check("zero_valid", 32'(out_valid), 32'h1);
        check("zero_illegal", 32'(illegal), 32'h1);
        check("zero_alu", 32'(ALUControl), 32'h0);
        check("zero_regw", 32'(RegWrite), 32'h0);
        check("zero_memw", 32'(MemWrite), 32'h0);

        @(posedge clk); #1;
        check("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: held bundle must stay put while a new offer waits.
        send(32'hFFF00293, 32'h0000_0200);
        out_ready   = 1'b0;
        instr       = 32'h123450B7;
        pc          = 32'h0000_0204;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_ready", 32'(instr_ready), 32'h0);
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_alu", 32'(ALUControl), 32'h0);
            check("stall_imm", ImmExt, 32'hFFFFFFFF);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(instr_ready), 32'h1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("release_valid", 32'(out_valid), 32'h1);
        check("release_alu", 32'(ALUControl), 32'h4);
        check("release_imm", ImmExt, 32'h12345000);
        check("release_pc", pc_out, 32'h0000_0204);

        // Flush alongside an acceptable offer while a bundle is held.
        flush       = 1'b1;
        instr       = 32'hFE209EE3;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", 32'(out_valid), 32'h0);
        flush       = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("flush_stays_empty", 32'(out_valid), 32'h0);

        // Asynchronous reset between clock edges discards the held bundle.
        send(32'hFFF00293, 32'h0000_0300);
        out_ready = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_ready", 32'(instr_ready), 32'h1);
        check("async_rst_alu", 32'(ALUControl), 32'h0);
        check("async_rst_imm", ImmExt, 32'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(32'h0000C203, 32'h0000_0400);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_alu", 32'(ALUControl), 32'h5);
        check("post_rst_pc", pc_out, 32'h0000_0400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, instruction/PC/immediate width; only 32 is supported.
REQ-002 One clock; reset is asynchronous and active-high. Ports: clk and rst.
REQ-003 Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch offers instr/pc.
- instr_ready  out  1  stage accepts the offer.
- instr  in  32  raw instruction word.
- pc  in  32  instruction address.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- ALUControl  out  4  ALU operation code.
- ALUSrc  out  1  1 = SrcB is ImmExt, 0 = SrcB is rs2 data.
- RegWrite  out  1  register writeback enable.
- MemWrite  out  1  store enable.
- ResultSrc  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- Branch  out  1  conditional branch.
- Jump  out  1  jal/jalr.
- ImmExt  out  32  extended immediate.
- rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- pc_out  out  32  PC of the decoded instruction.
- illegal  out  1  unsupported encoding.

Function
REQ-004 The stage is a single-entry pipeline register. All outputs except instr_ready are registered.
REQ-005 instr_ready = !out_valid || out_ready, combinationally.
REQ-006 Handshake rules:
- A transfer occurs on a rising edge with instr_valid && instr_ready && !flush.
- A transfer loads all output fields and sets out_valid; latency is 1 cycle.
- out_valid clears on an edge with out_valid && out_ready and no new transfer.
- Simultaneous consume and transfer: load the new bundle, out_valid stays 1.
REQ-007 While out_valid && !out_ready, all outputs hold stable and instr_ready = 0.
REQ-008 flush=1 at an edge clears out_valid and blocks any load that cycle; flush overrides an accept. Data fields may hold stale values.
REQ-009 ALUControl per instruction (opcode/funct3/funct7):
- 0000: add (0110011/000/0000000), addi (0010011/000).
- 0001: bne (1100011/001).
- 0010: jal (1101111).
- 0011: jalr (1100111/000).
- 0100: lui (0110111).
- 0101: lbu (0000011/100).
- 0110: sb (0100011/000).
- 0111: sll (0110011/001/0000000), slli (0010011/001/0000000).
- 1000: sub (0110011/000/0100000).
- 1001: srl (0110011/101/0000000), srli (0010011/101/0000000).
- 1010: xor, xori (funct3 100).
- 1011: or, ori (funct3 110).
- 1100: and, andi (funct3 111).
- 1101: beq (1100011/000).
REQ-010 ImmExt, sign-extended from instr[31]:
- I: instr[31:20].
- Shift-immediate: {27'b0, instr[24:20]}.
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- U: {instr[31:12], 12'b0}.
- R: 0.
REQ-011 ALUSrc = 1 for I-ALU, lbu, sb, jal, jalr, lui; 0 for R and branches.
REQ-012 RegWrite = 1 for R, I-ALU, lbu, jal, jalr, lui. MemWrite = 1 only for sb. Branch = 1 for beq/bne. Jump = 1 for jal/jalr.
REQ-013 ResultSrc = 01 for lbu, 10 for jal/jalr, 00 otherwise.
REQ-014 Any encoding not in REQ-009 sets illegal=1 and forces:
- ALUControl = 0000.
- RegWrite, MemWrite, Branch, Jump = 0.
- ImmExt = 0.
- out_valid behaves normally.

Reset
REQ-015 While rst=1:
- out_valid = 0, and instr_ready = 1 after reset.
- All other registered outputs = 0.
REQ-016 rst asserted mid-transfer discards the held bundle; the first accept after deassertion produces out_valid on the following edge.

Verification
REQ-017 Send addi x5,x0,-1 (0xFFF00293) with out_ready=1 -> next cycle:
- out_valid=1, ALUControl=0000, ALUSrc=1, RegWrite=1.
- ImmExt=0xFFFFFFFF, rd=5.
REQ-018 Send bne with instr 0xFE209EE3 -> ALUControl=0001, Branch=1, RegWrite=0, ImmExt=0xFFFFFFFC.
REQ-019 Send lui x1,0x12345 (0x123450B7) -> ALUControl=0100, ImmExt=0x12345000, ResultSrc=00.
REQ-020 Hold out_ready=0 with a bundle held and offer a new instruction -> instr_ready=0, outputs unchanged for 5 cycles. Then set out_ready=1 -> new bundle loaded the next edge, out_valid stays 1.
REQ-021 Assert flush together with a valid offer while a bundle is held -> next cycle out_valid=0.
REQ-022 Send 0x00000000 -> illegal=1, ALUControl=0000, RegWrite=0, MemWrite=0. Assert rst asynchronously mid-stream -> out_valid=0 immediately.
